grf_wr_arbiter: RTL and testbench
=================================

// Module: grf_wr_arbiter
// PURPOSE
//  Shares the single GRF write port between two requesters: src0 = pipeline W-stage
//  writeback, src1 = late results from the multi-cycle MDU/load path.
//  Arbitrates with valid/ready handshakes and registers the winner onto the port.
//  Drives the select for the 5b/32b write-port muxes. Sits between W stage/MDU and GRF.
// PARAMETERS
//  DW        32  write data width
//  AW        5   register address width
//  MAX_WAIT  4   cycles src1 may be refused while valid before forced grant (>=1)
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   reset, asynchronous, active-low
//  s0_valid      in   1   src0 write request
//  s0_addr       in   AW  src0 destination register
//  s0_data       in   DW  src0 write data
//  s0_ready      out  1   src0 granted this cycle (combinational)
//  s1_valid      in   1   src1 write request
//  s1_addr       in   AW  src1 destination register
//  s1_data       in   DW  src1 write data
//  s1_ready      out  1   src1 granted this cycle (combinational)
//  hold          in   1   no grant this cycle (GRF busy / debug freeze)
//  grf_we        out  1   registered GRF write enable
//  grf_waddr     out  AW  registered write address
//  grf_wdata     out  DW  registered write data
//  grf_sel       out  1   registered mux select: 0 = src0, 1 = src1
// BEHAVIOUR
//  - Reset: grf_we=0, grf_waddr=0, grf_wdata=0, grf_sel=0, wait_cnt=0, last_gnt=1.
//    Asynchronous assert; synchronous-safe deassert. Requesters keep valid asserted,
//    so a request in flight at reset is re-presented afterwards, not lost.
//  - Max one grant per cycle. Handshake = valid & ready. Requester holds valid, addr
//    and data stable until ready. ready never asserts without valid or while hold=1.
//  - Default policy: fixed priority to src0. Forced grant to src1 when
//    wait_cnt == MAX_WAIT.
//  - wait_cnt: increments while s1_valid & !s1_ready & !hold. Saturates at MAX_WAIT.
//    Clears on s1 grant or when s1_valid=0. Holds during hold.
//  - Latency: handshake in cycle N -> grf_we/waddr/wdata/sel valid in cycle N+1,
//    for exactly one cycle.
//  - No grant in cycle N (including hold) -> grf_we=0 in N+1. waddr/wdata/sel hold.
//  - Address 0: request is accepted (ready=1) but grf_we=0 the next cycle.
//    waddr/wdata still update.
//  - Same address from both sources: writes land in grant order. The later grant's
//    data is final. No merging.
//  - last_gnt records the source of the most recent grant. Used only by ARB_RR_EN.
// CONFIGURATION
//  ARB_RR_EN defined: round-robin. When both are valid, grant the source != last_gnt.
//    wait_cnt and MAX_WAIT are not instantiated.
//  ARB_RR_EN undefined: fixed priority plus starvation counter, as above.
//  The port list is identical in both builds.
// STRUCTURE
//  Shared package mips_defs: REG_ZERO = 5'd0, GRF_SRC_W = 1'b0, GRF_SRC_LATE = 1'b1,
//    GRF_AW = 5, GRF_DW = 32.
//  One sub-module: arb_wait_cnt (saturating counter: inc/clr/hold, width
//    $clog2(MAX_WAIT+1), out sat).
//  The rest is top-level grant logic plus output registers.
// TESTING
//  1 s0 only, addr=5'd8, data=32'hDEAD_BEEF -> s0_ready same cycle; next cycle
//    grf_we=1, waddr=8, wdata=DEAD_BEEF, sel=0.
//  2 Both valid continuously, MAX_WAIT=4 -> s0 granted 4 cycles, s1 granted in the
//    5th, then s0 again; counter clears after the s1 grant.
//  3 Both valid, both addr=5'd3, s0 data=1, s1 data=2 -> two single-cycle writes,
//    s0 then s1; final register value = 2.
//  4 s1 valid, addr=5'd0, data=32'h1234 -> s1_ready=1; next cycle grf_we=0.
//  5 hold=1 for 3 cycles with both valid -> no ready, grf_we=0, wait_cnt frozen;
//    grants resume the cycle hold drops.
//  6 rst_n low mid-stream (grf_we=1) -> all outputs 0 immediately, without a clock
//    edge; after release the held request is granted normally.
//    With ARB_RR_EN: both valid -> grants strictly alternate 0,1,0,1 starting with src0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS core definitions: GRF geometry, the zero register and write-port source encodings.
package mips_defs;

  localparam int GRF_AW = 5;
  localparam int GRF_DW = 32;

  localparam logic [GRF_AW-1:0] REG_ZERO = 5'd0;

  localparam logic GRF_SRC_W    = 1'b0;
  localparam logic GRF_SRC_LATE = 1'b1;

  typedef struct packed {
    logic              we;
    logic [GRF_AW-1:0] addr;
    logic [GRF_DW-1:0] data;
    logic              sel;
  } grf_wr_t;

  // A write to $zero is architecturally discarded but the port still handshakes.
  function automatic logic grf_addr_writable(input logic [GRF_AW-1:0] addr);
    return addr != REG_ZERO;
  endfunction

endpackage

// File: rtl/arb_wait_cnt.sv
// Saturating starvation counter for the late-result requester of the GRF write arbiter.
module arb_wait_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  input  logic hold_i,
  output logic sat_o
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign sat_o = (cnt_q == W'(MAX));

  // Clear dominates so a withdrawn or granted request always restarts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!hold_i && inc_i && !sat_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/grf_wr_arbiter.sv
// GRF write-port arbiter between W-stage writeback (src0) and late MDU/load results (src1).
// Define ARB_RR_EN for round-robin; default is src0 priority with a starvation counter.
module grf_wr_arbiter
  import mips_defs::*;
#(
  parameter int DW       = GRF_DW,
  parameter int AW       = GRF_AW,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s0_valid,
  input  logic [AW-1:0] s0_addr,
  input  logic [DW-1:0] s0_data,
  output logic          s0_ready,
  input  logic          s1_valid,
  input  logic [AW-1:0] s1_addr,
  input  logic [DW-1:0] s1_data,
  output logic          s1_ready,
  input  logic          hold,
  output logic          grf_we,
  output logic [AW-1:0] grf_waddr,
  output logic [DW-1:0] grf_wdata,
  output logic          grf_sel
);

  logic          gnt0;
  logic          gnt1;
  logic          gnt_any;
  logic          win_sel;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  logic          grf_we_q,    grf_we_d;
  logic [AW-1:0] grf_waddr_q, grf_waddr_d;
  logic [DW-1:0] grf_wdata_q, grf_wdata_d;
  logic          grf_sel_q,   grf_sel_d;

`ifdef ARB_RR_EN
  logic last_gnt_q;
  logic last_gnt_d;

  // On contention the source that did not win last time goes first.
  assign gnt1 = !hold && s1_valid && (!s0_valid || (last_gnt_q == GRF_SRC_W));
  assign gnt0 = !hold && s0_valid && !gnt1;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt1) begin
      last_gnt_d = GRF_SRC_LATE;
    end else if (gnt0) begin
      last_gnt_d = GRF_SRC_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= GRF_SRC_LATE;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`else
  logic wait_sat;
  logic wait_inc;
  logic wait_clr;

  // src0 wins unless src1 has been refused MAX_WAIT times in a row.
  assign gnt1 = !hold && s1_valid && (!s0_valid || wait_sat);
  assign gnt0 = !hold && s0_valid && !gnt1;

  assign wait_inc = s1_valid && !gnt1 && !hold;
  assign wait_clr = gnt1 || !s1_valid;

  arb_wait_cnt #(
    .MAX (MAX_WAIT)
  ) u_wait_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (wait_inc),
    .clr_i  (wait_clr),
    .hold_i (hold),
    .sat_o  (wait_sat)
  );
`endif

  assign s0_ready = gnt0;
  assign s1_ready = gnt1;
  assign gnt_any  = gnt0 || gnt1;

  assign win_sel  = gnt1 ? GRF_SRC_LATE : GRF_SRC_W;
  assign win_addr = gnt1 ? s1_addr : s0_addr;
  assign win_data = gnt1 ? s1_data : s0_data;

  // Address/data/select only move on a grant; enable is a one-cycle pulse.
  always_comb begin
    grf_we_d    = 1'b0;
    grf_waddr_d = grf_waddr_q;
    grf_wdata_d = grf_wdata_q;
    grf_sel_d   = grf_sel_q;
    if (gnt_any) begin
      grf_we_d    = (win_addr != AW'(REG_ZERO));
      grf_waddr_d = win_addr;
      grf_wdata_d = win_data;
      grf_sel_d   = win_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grf_we_q    <= 1'b0;
      grf_waddr_q <= '0;
      grf_wdata_q <= '0;
      grf_sel_q   <= GRF_SRC_W;
    end else begin
      grf_we_q    <= grf_we_d;
      grf_waddr_q <= grf_waddr_d;
      grf_wdata_q <= grf_wdata_d;
      grf_sel_q   <= grf_sel_d;
    end
  end

  assign grf_we    = grf_we_q;
  assign grf_waddr = grf_waddr_q;
  assign grf_wdata = grf_wdata_q;
  assign grf_sel   = grf_sel_q;

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Directed self-checking bench for grf_wr_arbiter in its default fixed-priority build.
module tb_grf_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic        s0_valid;
  logic [4:0]  s0_addr;
  logic [31:0] s0_data;
  logic        s0_ready;
  logic        s1_valid;
  logic [4:0]  s1_addr;
  logic [31:0] s1_data;
  logic        s1_ready;
  logic        hold;
  logic        grf_we;
  logic [4:0]  grf_waddr;
  logic [31:0] grf_wdata;
  logic        grf_sel;

  int testsRun;
  int testsFailed;
  logic [31:0] reg3Model;

  grf_wr_arbiter #(
    .DW       (32),
    .AW       (5),
    .MAX_WAIT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s0_valid  (s0_valid),
    .s0_addr   (s0_addr),
    .s0_data   (s0_data),
    .s0_ready  (s0_ready),
    .s1_valid  (s1_valid),
    .s1_addr   (s1_addr),
    .s1_data   (s1_data),
    .s1_ready  (s1_ready),
    .hold      (hold),
    .grf_we    (grf_we),
    .grf_waddr (grf_waddr),
    .grf_wdata (grf_wdata),
    .grf_sel   (grf_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs and let combinational ready settle.
  task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic h);
    s0_valid = v0;
    s0_addr  = a0;
    s0_data  = d0;
    s1_valid = v1;
    s1_addr  = a1;
    s1_data  = d1;
    hold     = h;
    #1;
  endtask

  task automatic checkReady(input string tag, input logic e0, input logic e1);
    testsRun++;
    assert (s0_ready === e0) else begin
      testsFailed++;
      $error("[TB] FAIL %s s0_ready observed=%b expected=%b", tag, s0_ready, e0);
    end
    testsRun++;
    assert (s1_ready === e1) else begin
      testsFailed++;
      $error("[TB] FAIL %s s1_ready observed=%b expected=%b", tag, s1_ready, e1);
    end
  endtask

  task automatic checkOutput(input string tag, input logic eWe, input logic [4:0] eAddr,
                             input logic [31:0] eData, input logic eSel);
    testsRun++;
    assert ({grf_we, grf_waddr, grf_wdata, grf_sel} === {eWe, eAddr, eData, eSel}) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed we=%b addr=%0d data=%h sel=%b expected we=%b addr=%0d data=%h sel=%b",
             tag, grf_we, grf_waddr, grf_wdata, grf_sel, eWe, eAddr, eData, eSel);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reg3Model   = 32'h0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput("reset", 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single src0 write.
    applyStimulus(1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0);
    checkReady("t1_ready", 1'b1, 1'b0);
    tick();
    checkOutput("t1_write", 1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkReady("t1_idle_ready", 1'b0, 1'b0);
    tick();
    checkOutput("t1_idle", 1'b0, 5'd8, 32'hDEAD_BEEF, 1'b0);

    // Continuous contention: four src0 grants, forced src1, then src0 again.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'd1, 32'h10 + 32'(i), 1'b1, 5'd2, 32'h55, 1'b0);
      checkReady($sformatf("t2_s0_%0d", i), 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("t2_w0_%0d", i), 1'b1, 5'd1, 32'h10 + 32'(i), 1'b0);
    end
    applyStimulus(1'b1, 5'd1, 32'h14, 1'b1, 5'd2, 32'h55, 1'b0);
    checkReady("t2_forced", 1'b0, 1'b1);
    tick();
    checkOutput("t2_w1", 1'b1, 5'd2, 32'h55, 1'b1);
    applyStimulus(1'b1, 5'd1, 32'h14, 1'b1, 5'd2, 32'h66, 1'b0);
    checkReady("t2_after_clear", 1'b1, 1'b0);
    tick();
    checkOutput("t2_w0_again", 1'b1, 5'd1, 32'h14, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();

    // Same destination from both sources: later grant wins.
    applyStimulus(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2, 1'b0);
    checkReady("t3_first", 1'b1, 1'b0);
    tick();
    checkOutput("t3_w0", 1'b1, 5'd3, 32'h1, 1'b0);
    if (grf_we && grf_waddr == 5'd3) reg3Model = grf_wdata;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h2, 1'b0);
    checkReady("t3_second", 1'b0, 1'b1);
    tick();
    checkOutput("t3_w1", 1'b1, 5'd3, 32'h2, 1'b1);
    if (grf_we && grf_waddr == 5'd3) reg3Model = grf_wdata;
    testsRun++;
    assert (reg3Model === 32'h2) else begin
      testsFailed++;
      $error("[TB] FAIL t3_final reg3 observed=%h expected=%h", reg3Model, 32'h2);
    end

    // Write to $zero is accepted but never enabled.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0);
    checkReady("t4_ready", 1'b0, 1'b1);
    tick();
    checkOutput("t4_zero", 1'b0, 5'd0, 32'h1234, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();

    // Two refusals, three held cycles, then two more refusals before the forced grant.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 5'd4, 32'hA0 + 32'(i), 1'b1, 5'd5, 32'hB0, 1'b0);
      checkReady($sformatf("t5_pre_%0d", i), 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd4, 32'hA2, 1'b1, 5'd5, 32'hB0, 1'b1);
      checkReady($sformatf("t5_hold_%0d", i), 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("t5_hold_out_%0d", i), 1'b0, 5'd4, 32'hA1, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 5'd4, 32'hA2 + 32'(i), 1'b1, 5'd5, 32'hB0, 1'b0);
      checkReady($sformatf("t5_resume_%0d", i), 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 5'd4, 32'hA4, 1'b1, 5'd5, 32'hB0, 1'b0);
    checkReady("t5_forced", 1'b0, 1'b1);
    tick();
    checkOutput("t5_w1", 1'b1, 5'd5, 32'hB0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();

    // Asynchronous reset mid-stream; held request is re-granted afterwards.
    applyStimulus(1'b1, 5'd9, 32'hA5A5_0009, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    checkOutput("t6_before", 1'b1, 5'd9, 32'hA5A5_0009, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async", 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    checkReady("t6_rerequest", 1'b1, 1'b0);
    tick();
    checkOutput("t6_after", 1'b1, 5'd9, 32'hA5A5_0009, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
